uart_tx_ctrl: RTL and testbench

Frame sequencer for the baud counter datapath: owns a programmable-modulus bit-period counter and uses its wrap events to shift one byte out as an 8N1 UART frame on a single pin. Sits between a byte producer (valid/ready handshake) and the board's TX pin on the J3 header. All sequential logic runs on the board clock.

---
 rtl/uart_tx_ctrl.sv | 123 ++++++++++++
 tb/tb_uart_tx_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - 8N1 UART frame sequencer driven by a programmable bit-period counter
// Accepts one byte per valid/ready handshake and shifts it out LSB first on TX.

module uart_tx_ctrl #(
  parameter int DIV_WIDTH = 4,
  parameter int DATA_BITS = 8
) (
  input  logic                 CLKIN,
  input  logic                 RESET,
  input  logic [DIV_WIDTH-1:0] DIV,
  input  logic [DATA_BITS-1:0] DATA,
  input  logic                 VALID,
  output logic                 READY,
  output logic                 TX,
  output logic                 BUSY,
  output logic                 TICK
);

  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t               r_state;
  logic [DIV_WIDTH-1:0] r_cnt;
  logic [DIV_WIDTH-1:0] r_div;
  logic [IDX_W-1:0]     r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_tx;
  logic                 r_busy;
  logic                 r_ready;

  logic                 w_tick;
  logic                 w_last_bit;

  // Bit period ends when the counter reaches the divisor latched at acceptance.
  assign w_tick     = (r_state != S_IDLE) && (r_cnt == r_div);
  assign w_last_bit = (r_idx == LAST_IDX);

  assign READY = r_ready;
  assign TX    = r_tx;
  assign BUSY  = r_busy;
  assign TICK  = w_tick;

  always_ff @(posedge CLKIN) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_div   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      if (r_state == S_IDLE) begin
        r_cnt <= '0;
      end else if (w_tick) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (VALID && r_ready) begin
            r_shift <= DATA;
            r_div   <= DIV;
            r_idx   <= '0;
            r_state <= S_START;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
          end
        end

        S_START: begin
          if (w_tick) begin
            r_idx   <= '0;
            r_state <= S_DATA;
            r_tx    <= r_shift[0];
          end
        end

        S_DATA: begin
          if (w_tick) begin
            r_shift <= r_shift >> 1;
            if (w_last_bit) begin
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_idx <= r_idx + 1'b1;
              // Next bit is the one about to land in shift[0] after this shift.
              r_tx  <= r_shift[1];
            end
          end
        end

        S_STOP: begin
          if (w_tick) begin
            r_state <= S_IDLE;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - self-checking bench for uart_tx_ctrl
// Per-cycle expected outputs are queued when a byte is offered and popped each cycle.

module tb_uart_tx_ctrl;

  logic       CLKIN = 1'b0;
  logic       RESET;
  logic [3:0] DIV;
  logic [7:0] DATA;
  logic       VALID;
  logic       READY;
  logic       TX;
  logic       BUSY;
  logic       TICK;

  uart_tx_ctrl #(.DIV_WIDTH(4), .DATA_BITS(8)) dut (
    .CLKIN(CLKIN),
    .RESET(RESET),
    .DIV(DIV),
    .DATA(DATA),
    .VALID(VALID),
    .READY(READY),
    .TX(TX),
    .BUSY(BUSY),
    .TICK(TICK)
  );

  always #5 CLKIN = ~CLKIN;

  typedef struct packed {
    logic tx;
    logic busy;
    logic ready;
    logic tick;
  } obs_t;

  typedef struct {
    int         div;
    logic [7:0] data;
    int         act;
    int         exp_busy;
    int         exp_ticks;
  } vec_t;

  obs_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   busy_cnt;
  int   tick_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Spec-level frame model: start bit, DATA LSB first, stop bit, each div+1 cycles.
  task automatic push_frame(input int div, input logic [7:0] data);
    int   per;
    int   k;
    obs_t o;
    per = div + 1;
    for (int c = 1; c <= 10 * per; c++) begin
      k = (c - 1) / per;
      o.tx    = (k == 0) ? 1'b0 : ((k <= 8) ? data[k-1] : 1'b1);
      o.busy  = 1'b1;
      o.ready = 1'b0;
      o.tick  = ((c % per) == 0);
      exp_q.push_back(o);
    end
    o = '{tx: 1'b1, busy: 1'b0, ready: 1'b1, tick: 1'b0};
    exp_q.push_back(o);
  endtask

  task automatic cycle();
    obs_t e;
    @(negedge CLKIN);
    if (BUSY === 1'b1) busy_cnt++;
    if (TICK === 1'b1) tick_cnt++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("tx",    32'(TX),    32'(e.tx));
      chk("busy",  32'(BUSY),  32'(e.busy));
      chk("ready", 32'(READY), 32'(e.ready));
      chk("tick",  32'(TICK),  32'(e.tick));
    end
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 3000 && exp_q.size() > 0; n++) cycle();
    chk(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // act 1: change DIV/DATA mid-frame; act 2: offer another byte while busy.
  task automatic run_frame(input vec_t v);
    chk("ready_before", 32'(READY), 32'd1);
    DIV   = 4'(v.div);
    DATA  = v.data;
    VALID = 1'b1;
    push_frame(v.div, v.data);
    busy_cnt = 0;
    tick_cnt = 0;
    for (int n = 0; n < 3000 && exp_q.size() > 0; n++) begin
      cycle();
      if (n == 0) VALID = 1'b0;
      if (v.act == 1 && n == 20) begin
        DIV  = 4'd1;
        DATA = 8'h00;
      end
      if (v.act == 2 && n == 5) begin
        VALID = 1'b1;
        DATA  = 8'h55;
      end
      if (v.act == 2 && n == 6) VALID = 1'b0;
    end
    chk("frame_done", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    chk("busy_len",  32'(busy_cnt), 32'(v.exp_busy));
    chk("tick_cnt",  32'(tick_cnt), 32'(v.exp_ticks));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    vec_t v;
    vecs[0] = '{div: 3,  data: 8'hA5, act: 0, exp_busy: 40,  exp_ticks: 10};
    vecs[1] = '{div: 15, data: 8'hFF, act: 1, exp_busy: 160, exp_ticks: 10};
    vecs[2] = '{div: 1,  data: 8'hC3, act: 2, exp_busy: 20,  exp_ticks: 10};
    vecs[3] = '{div: 0,  data: 8'h5A, act: 0, exp_busy: 10,  exp_ticks: 10};
    vecs[4] = '{div: 15, data: 8'h00, act: 0, exp_busy: 160, exp_ticks: 10};

    RESET = 1'b1;
    VALID = 1'b1;
    DIV   = 4'd0;
    DATA  = 8'hA5;
    busy_cnt = 0;
    tick_cnt = 0;

    // Reset held two edges with VALID high: no frame may start.
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("rst_tx",    32'(TX),    32'd1);
      chk("rst_busy",  32'(BUSY),  32'd0);
      chk("rst_ready", 32'(READY), 32'd1);
      chk("rst_tick",  32'(TICK),  32'd0);
    end
    RESET = 1'b0;
    VALID = 1'b0;
    cycle();
    chk("post_rst_tx",    32'(TX),    32'd1);
    chk("post_rst_busy",  32'(BUSY),  32'd0);
    chk("post_rst_ready", 32'(READY), 32'd1);
    chk("post_rst_tick",  32'(TICK),  32'd0);

    foreach (vecs[i]) run_frame(vecs[i]);

    // VALID held high at DIV=0: back-to-back frames, one idle cycle apart.
    DIV   = 4'd0;
    DATA  = 8'h00;
    VALID = 1'b1;
    busy_cnt = 0;
    tick_cnt = 0;
    for (int f = 0; f < 3; f++) push_frame(0, 8'h00);
    for (int n = 0; n < 3000 && exp_q.size() > 0; n++) cycle();
    VALID = 1'b0;
    chk("b2b_done",  32'(exp_q.size()), 32'd0);
    exp_q.delete();
    chk("b2b_busy",  32'(busy_cnt), 32'd30);
    chk("b2b_ticks", 32'(tick_cnt), 32'd30);
    cycle();
    chk("b2b_no_4th", 32'(BUSY), 32'd0);

    // Reset during data bit 3 (cycles 13..15 at DIV=2) aborts the frame.
    DIV   = 4'd2;
    DATA  = 8'h0F;
    VALID = 1'b1;
    push_frame(2, 8'h0F);
    for (int n = 0; n < 13; n++) begin
      cycle();
      if (n == 0) VALID = 1'b0;
    end
    exp_q.delete();
    RESET = 1'b1;
    cycle();
    RESET = 1'b0;
    chk("abort_tx",    32'(TX),    32'd1);
    chk("abort_busy",  32'(BUSY),  32'd0);
    chk("abort_ready", 32'(READY), 32'd1);
    chk("abort_tick",  32'(TICK),  32'd0);
    tick_cnt = 0;
    busy_cnt = 0;
    for (int n = 0; n < 20; n++) cycle();
    chk("abort_no_ticks", 32'(tick_cnt), 32'd0);
    chk("abort_no_busy",  32'(busy_cnt), 32'd0);
    v = '{div: 2, data: 8'h3C, act: 0, exp_busy: 30, exp_ticks: 10};
    run_frame(v);

    // Line stays idle once all frames are done.
    for (int n = 0; n < 4; n++) exp_q.push_back('{tx: 1'b1, busy: 1'b0, ready: 1'b1, tick: 1'b0});
    drain("idle_tail");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
